emulib_fifo_flex: RTL and testbench

EMULIB_FIFO_FLEX -- requirements
Module: emulib_fifo_flex

---
 rtl/emulib_fifo_pkg.sv | 12 +
 rtl/emulib_fifo_ram.sv | 25 ++
 rtl/emulib_fifo_flex.sv | 124 ++++++++++++
 tb/tb_emulib_fifo_flex.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/emulib_fifo_pkg.sv
// rtl/emulib_fifo_pkg.sv - shared constants and pointer helper for the flexible FIFO
package emulib_fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Pointer increment that wraps at an arbitrary (non power-of-two) depth.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/emulib_fifo_ram.sv
// rtl/emulib_fifo_ram.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read, no reset
module emulib_fifo_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/emulib_fifo_flex.sv
// rtl/emulib_fifo_flex.sv - parameterised FIFO control: pointers, count, registered flags and
// registered-read or first-word-fall-through output stage
module emulib_fifo_flex
    import emulib_fifo_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 8,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    parameter int CNTW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             winc,
    input  logic [WIDTH-1:0] wdata,
    output logic             wfull,
    input  logic             rinc,
    output logic [WIDTH-1:0] rdata,
    output logic             rempty,
    output logic [CNTW-1:0]  count,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             wovf,
    output logic             rudf
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (WIDTH < 1 || DEPTH < 1 || (FWFT != FWFT_OFF && FWFT != FWFT_ON) ||
        AFULL_THRESH < 1 || AFULL_THRESH > DEPTH ||
        AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1 ||
        CNTW < $clog2(DEPTH + 1)) begin : g_bad_param
        $fatal(1, "emulib_fifo_flex: illegal parameter value");
    end

    logic [PTRW-1:0]  wptr;
    logic [PTRW-1:0]  rptr;
    logic             wfire;
    logic             rfire;
    logic [CNTW-1:0]  count_nxt;
    logic [WIDTH-1:0] ram_rdata;

    assign wfire = winc && !wfull && !flush;
    assign rfire = rinc && !rempty && !flush;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (wfire && !rfire) begin
            count_nxt = count + CNTW'(1);
        end else if (rfire && !wfire) begin
            count_nxt = count - CNTW'(1);
        end
    end

    // Flags are registered from the next count so they always agree with the registered count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            wfull        <= 1'b0;
            rempty       <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            wovf         <= 1'b0;
            rudf         <= 1'b0;
        end else begin
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wfire) begin
                    wptr <= PTRW'(ptr_inc(32'(wptr), DEPTH));
                end
                if (rfire) begin
                    rptr <= PTRW'(ptr_inc(32'(rptr), DEPTH));
                end
            end
            count        <= count_nxt;
            wfull        <= (count_nxt == CNTW'(DEPTH));
            rempty       <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CNTW'(AFULL_THRESH));
            almost_empty <= (count_nxt <= CNTW'(AEMPTY_THRESH));
            wovf         <= winc && wfull && !flush;
            // A read on empty paired with an accepted write is not an underflow.
            rudf         <= rinc && rempty && !flush && !wfire;
        end
    end

    emulib_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTRW)
    ) u_ram (
        .clk   (clk),
        .we    (wfire),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (rptr),
        .rdata (ram_rdata)
    );

    if (FWFT == FWFT_ON) begin : g_fwft
        // Head entry is visible as soon as the registered rempty falls.
        assign rdata = rempty ? '0 : ram_rdata;
    end else begin : g_reg
        logic [WIDTH-1:0] rdata_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else if (rfire) begin
                rdata_q <= ram_rdata;
            end
        end

        assign rdata = rdata_q;
    end

endmodule

// File: tb/tb_emulib_fifo_flex.sv
// tb/tb_emulib_fifo_flex.sv - directed bench for emulib_fifo_flex in both read modes
module tb_emulib_fifo_flex;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic       winc  = 1'b0;
    logic       rinc  = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] rdata0, rdata1;
    logic [2:0] count0, count1;
    logic       wfull0, wfull1, rempty0, rempty1;
    logic       af0, af1, ae0, ae1;
    logic       wovf0, wovf1, rudf0, rudf1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    emulib_fifo_flex #(
        .WIDTH (8), .DEPTH (5), .FWFT (0), .AFULL_THRESH (4), .AEMPTY_THRESH (1)
    ) u_reg (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .winc (winc), .wdata (wdata), .wfull (wfull0),
        .rinc (rinc), .rdata (rdata0), .rempty (rempty0),
        .count (count0), .almost_full (af0), .almost_empty (ae0),
        .wovf (wovf0), .rudf (rudf0)
    );

    emulib_fifo_flex #(
        .WIDTH (8), .DEPTH (5), .FWFT (1), .AFULL_THRESH (4), .AEMPTY_THRESH (1)
    ) u_fwft (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .winc (winc), .wdata (wdata), .wfull (wfull1),
        .rinc (rinc), .rdata (rdata1), .rempty (rempty1),
        .count (count1), .almost_full (af1), .almost_empty (ae1),
        .wovf (wovf1), .rudf (rudf1)
    );

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_stat(input string tag, input logic [2:0] c, input logic full,
                            input logic empty, input logic afull, input logic aempty);
        chk_cnt({tag, ".count0"}, count0, c);
        chk_cnt({tag, ".count1"}, count1, c);
        chk_bit({tag, ".wfull0"}, wfull0, full);
        chk_bit({tag, ".wfull1"}, wfull1, full);
        chk_bit({tag, ".rempty0"}, rempty0, empty);
        chk_bit({tag, ".rempty1"}, rempty1, empty);
        chk_bit({tag, ".afull0"}, af0, afull);
        chk_bit({tag, ".afull1"}, af1, afull);
        chk_bit({tag, ".aempty0"}, ae0, aempty);
        chk_bit({tag, ".aempty1"}, ae1, aempty);
    endtask

    task automatic chk_pulse(input string tag, input logic ovf, input logic udf);
        chk_bit({tag, ".wovf0"}, wovf0, ovf);
        chk_bit({tag, ".wovf1"}, wovf1, ovf);
        chk_bit({tag, ".rudf0"}, rudf0, udf);
        chk_bit({tag, ".rudf1"}, rudf1, udf);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk_stat("rst_async", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_pulse("rst_async", 1'b0, 1'b0);
        chk_byte("rst_async.rdata0", rdata0, 8'h00);
        chk_byte("rst_async.rdata1", rdata1, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // fill 0x01..0x05
        for (int i = 1; i <= 5; i++) begin
            winc  = 1'b1;
            wdata = 8'(i);
            step();
            chk_stat("fill", 3'(i), (i == 5), 1'b0, (i >= 4), (i <= 1));
            chk_byte("fill.rdata1", rdata1, 8'h01);
        end
        chk_byte("fill.rdata0", rdata0, 8'h00);

        // overflow attempt
        wdata = 8'h06;
        step();
        chk_pulse("ovf", 1'b1, 1'b0);
        chk_stat("ovf", 3'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        winc = 1'b0;
        step();
        chk_pulse("ovf_end", 1'b0, 1'b0);
        chk_cnt("ovf_end.count0", count0, 3'd5);

        // full with write+read: read wins, 0xEE dropped
        winc  = 1'b1;
        rinc  = 1'b1;
        wdata = 8'hEE;
        step();
        chk_stat("full_wr_rd", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_byte("full_wr_rd.rdata0", rdata0, 8'h01);
        chk_byte("full_wr_rd.rdata1", rdata1, 8'h02);

        // 7 write/read pairs across the pointer wrap
        for (int k = 0; k < 7; k++) begin
            wdata = 8'(k + 6);
            step();
            chk_byte("pair.rdata0", rdata0, 8'(k + 2));
            chk_byte("pair.rdata1", rdata1, 8'(k + 3));
            chk_cnt("pair.count0", count0, 3'd4);
            chk_cnt("pair.count1", count1, 3'd4);
        end

        // drain remaining 0x09..0x0C
        winc = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_byte("drain.rdata0", rdata0, 8'(k + 9));
            chk_cnt("drain.count0", count0, 3'(3 - k));
            if (k < 3) chk_byte("drain.rdata1", rdata1, 8'(k + 10));
        end
        rinc = 1'b0;
        step();
        chk_stat("drained", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

        // read on empty: single-cycle underflow pulse, rdata held
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        chk_pulse("udf", 1'b0, 1'b1);
        chk_byte("udf.rdata0", rdata0, 8'h0C);
        step();
        chk_pulse("udf_end", 1'b0, 1'b0);
        chk_byte("udf_end.rdata0", rdata0, 8'h0C);

        // empty with write+read: write wins, no underflow
        winc  = 1'b1;
        rinc  = 1'b1;
        wdata = 8'h5A;
        step();
        winc = 1'b0;
        chk_stat("empty_wr_rd", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_pulse("empty_wr_rd", 1'b0, 1'b0);
        chk_byte("empty_wr_rd.rdata0", rdata0, 8'h0C);
        chk_byte("empty_wr_rd.rdata1", rdata1, 8'h5A);
        step();
        rinc = 1'b0;
        chk_byte("empty_wr_rd_pop.rdata0", rdata0, 8'h5A);
        chk_cnt("empty_wr_rd_pop.count0", count0, 3'd0);

        // read latency of a single entry
        winc  = 1'b1;
        wdata = 8'hA5;
        step();
        winc = 1'b0;
        chk_bit("lat.rempty1", rempty1, 1'b0);
        chk_byte("lat.rdata1", rdata1, 8'hA5);
        chk_byte("lat.rdata0_before", rdata0, 8'h5A);
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        chk_byte("lat.rdata0", rdata0, 8'hA5);
        chk_stat("lat", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

        // flush with count=3 overrides simultaneous write and read
        winc = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wdata = 8'(i * 8'h11);
            step();
        end
        chk_stat("pre_flush", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        rinc  = 1'b1;
        wdata = 8'h44;
        step();
        flush = 1'b0;
        winc  = 1'b0;
        rinc  = 1'b0;
        chk_stat("flush", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_pulse("flush", 1'b0, 1'b0);
        chk_byte("flush.rdata0", rdata0, 8'hA5);
        step();
        chk_cnt("flush_idle.count1", count1, 3'd0);
        winc  = 1'b1;
        wdata = 8'h55;
        step();
        winc = 1'b0;
        chk_byte("post_flush.rdata1", rdata1, 8'h55);
        chk_cnt("post_flush.count0", count0, 3'd1);
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        chk_byte("post_flush.rdata0", rdata0, 8'h55);
        chk_cnt("post_flush_pop.count0", count0, 3'd0);

        // asynchronous reset mid-cycle with count=3
        winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wdata = 8'(8'h61 + i);
            step();
        end
        winc = 1'b0;
        chk_cnt("pre_rst.count0", count0, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        chk_stat("rst_mid", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_pulse("rst_mid", 1'b0, 1'b0);
        chk_byte("rst_mid.rdata0", rdata0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        winc  = 1'b1;
        wdata = 8'h3C;
        step();
        winc = 1'b0;
        chk_byte("after_rst.rdata1", rdata1, 8'h3C);
        chk_cnt("after_rst.count1", count1, 3'd1);
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        chk_byte("after_rst.rdata0", rdata0, 8'h3C);
        chk_stat("after_rst_pop", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
